// File: rtl/gpr_file.sv
// gpr_file: integer register file fed by the writeback stage.
//
// Purpose:
//   - 31 general-purpose registers (x1..x31); x0 is hard-wired to zero.
//   - Two combinational read ports with same-cycle write-to-read bypass.
//   - Single-entry trap capture latch drained by the trap unit via valid/ack.
//   - Counter of committed register writes (wraps modulo 2^XLEN).
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   wb_rd, wb_wd, wb_we              writeback write port
//   exc_in, exc_pc_in, exc_cause_in  exception report from writeback
//   rs1_addr/rs1_data, rs2_addr/rs2_data   combinational read ports
//   trap_valid, trap_pc, trap_cause, trap_overrun, trap_ack   trap latch
//   commit_count                     committed-write counter
module gpr_file #(
  parameter int unsigned XLEN = 32'd64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            wb_we,
  input  logic            exc_in,
  input  logic [XLEN-1:0] exc_pc_in,
  input  logic [3:0]      exc_cause_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic [3:0]      trap_cause,
  output logic            trap_overrun,
  input  logic            trap_ack,
  output logic [XLEN-1:0] commit_count
);

  typedef enum logic {
    TRAP_EMPTY = 1'b0,
    TRAP_FULL  = 1'b1
  } trap_state_t;

  logic [XLEN-1:0] r_regs [0:31];
  logic [XLEN-1:0] r_commit_count;
  trap_state_t     r_trap_state;
  logic [XLEN-1:0] r_trap_pc;
  logic [3:0]      r_trap_cause;
  logic            r_trap_overrun;

  logic            w_commit;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  // An exception in the same cycle squashes the write; x0 is never written.
  assign w_commit = wb_we && (wb_rd != 5'd0) && !exc_in;

  // Register array and commit counter update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
      r_commit_count <= {XLEN{1'b0}};
    end else begin
      if (w_commit) begin
        r_regs[wb_rd]  <= wb_wd;
        r_commit_count <= r_commit_count + {{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read port 1: x0 first, then bypass of a committing write, then storage.
  always_comb begin
    w_rs1_data = {XLEN{1'b0}};
    if (rs1_addr == 5'd0) begin
      w_rs1_data = {XLEN{1'b0}};
    end else if (w_commit && (wb_rd == rs1_addr)) begin
      w_rs1_data = wb_wd;
    end else begin
      w_rs1_data = r_regs[rs1_addr];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    w_rs2_data = {XLEN{1'b0}};
    if (rs2_addr == 5'd0) begin
      w_rs2_data = {XLEN{1'b0}};
    end else if (w_commit && (wb_rd == rs2_addr)) begin
      w_rs2_data = wb_wd;
    end else begin
      w_rs2_data = r_regs[rs2_addr];
    end
  end

  // Trap capture latch: EMPTY/FULL with sticky overrun flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_trap_state   <= TRAP_EMPTY;
      r_trap_pc      <= {XLEN{1'b0}};
      r_trap_cause   <= 4'd0;
      r_trap_overrun <= 1'b0;
    end else begin
      case (r_trap_state)
        TRAP_EMPTY: begin
          // An ack while empty has nothing to consume and is ignored.
          if (exc_in) begin
            r_trap_pc    <= exc_pc_in;
            r_trap_cause <= exc_cause_in;
            r_trap_state <= TRAP_FULL;
          end else begin
            r_trap_state <= TRAP_EMPTY;
          end
        end
        TRAP_FULL: begin
          if (trap_ack) begin
            // Accepted ack clears overrun; a simultaneous exception is a
            // lossless hand-off and refills the latch.
            r_trap_overrun <= 1'b0;
            if (exc_in) begin
              r_trap_pc    <= exc_pc_in;
              r_trap_cause <= exc_cause_in;
              r_trap_state <= TRAP_FULL;
            end else begin
              r_trap_state <= TRAP_EMPTY;
            end
          end else if (exc_in) begin
            // Keep the older trap; record that a newer one was lost.
            r_trap_overrun <= 1'b1;
          end else begin
            r_trap_state <= TRAP_FULL;
          end
        end
        default: begin
          r_trap_state <= TRAP_EMPTY;
        end
      endcase
    end
  end

  assign rs1_data     = w_rs1_data;
  assign rs2_data     = w_rs2_data;
  assign trap_valid   = (r_trap_state == TRAP_FULL);
  assign trap_pc      = r_trap_pc;
  assign trap_cause   = r_trap_cause;
  assign trap_overrun = r_trap_overrun;
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: stimulus queues expected values, a monitor
// process pops and compares them against the DUT outputs.
module tb_gpr_file;

  localparam int unsigned XLEN = 32'd64;

  logic            clk;
  logic            resetn;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            wb_we;
  logic            exc_in;
  logic [XLEN-1:0] exc_pc_in;
  logic [3:0]      exc_cause_in;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [3:0]      trap_cause;
  logic            trap_overrun;
  logic            trap_ack;
  logic [XLEN-1:0] commit_count;

  gpr_file #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_we(wb_we),
    .exc_in(exc_in), .exc_pc_in(exc_pc_in), .exc_cause_in(exc_cause_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_overrun(trap_overrun), .trap_ack(trap_ack),
    .commit_count(commit_count)
  );

  localparam logic [3:0] S_RS1 = 4'd0, S_RS2 = 4'd1, S_TV = 4'd2, S_TPC = 4'd3,
                         S_TC = 4'd4, S_OVR = 4'd5, S_CC = 4'd6;

  typedef struct packed {
    logic [7:0]  tag;
    logic [3:0]  sel;
    logic [63:0] exp;
  } exp_t;

  exp_t  sb_q[$];
  event  chk_ev;
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sel_name(input logic [3:0] s);
    case (s)
      S_RS1:   return "rs1_data";
      S_RS2:   return "rs2_data";
      S_TV:    return "trap_valid";
      S_TPC:   return "trap_pc";
      S_TC:    return "trap_cause";
      S_OVR:   return "trap_overrun";
      S_CC:    return "commit_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [63:0] actual(input logic [3:0] s);
    case (s)
      S_RS1:   return rs1_data;
      S_RS2:   return rs2_data;
      S_TV:    return {63'd0, trap_valid};
      S_TPC:   return trap_pc;
      S_TC:    return {60'd0, trap_cause};
      S_OVR:   return {63'd0, trap_overrun};
      S_CC:    return commit_count;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Monitor: whenever the stimulus signals outputs are settled, drain queue.
  initial begin
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [63:0] a;
        e = sb_q.pop_front();
        a = actual(e.sel);
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL step%0d %s actual=%h expected=%h", e.tag, sel_name(e.sel), a, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input logic [7:0] tag, input logic [3:0] sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic fire();
    -> chk_ev;
    #0.1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 64'd0;
    exc_in = 1'b0; exc_pc_in = 64'd0; exc_cause_in = 4'd0;
    trap_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #50;
    resetn = 1'b1;

    // 1: reset state
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    #1;
    expect_v(8'd1, S_RS1, 64'd0);
    expect_v(8'd1, S_RS2, 64'd0);
    expect_v(8'd1, S_TV, 64'd0);
    expect_v(8'd1, S_TPC, 64'd0);
    expect_v(8'd1, S_TC, 64'd0);
    expect_v(8'd1, S_OVR, 64'd0);
    expect_v(8'd1, S_CC, 64'd0);
    fire();

    // 2: write x3 with same-cycle bypass on port 1
    tick();
    wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 64'hDEAD_BEEF; rs1_addr = 5'd3;
    #1;
    expect_v(8'd2, S_RS1, 64'hDEAD_BEEF);
    expect_v(8'd2, S_CC, 64'd0);
    fire();

    // 3: stored value after the edge
    tick();
    idle_inputs();
    #1;
    expect_v(8'd3, S_RS1, 64'hDEAD_BEEF);
    expect_v(8'd3, S_CC, 64'd1);
    fire();

    // 4: write x4; port 2 bypasses, port 1 reads stored x3
    wb_we = 1'b1; wb_rd = 5'd4; wb_wd = 64'h1234_5678_9ABC_DEF0; rs2_addr = 5'd4;
    #1;
    expect_v(8'd4, S_RS1, 64'hDEAD_BEEF);
    expect_v(8'd4, S_RS2, 64'h1234_5678_9ABC_DEF0);
    fire();

    // 5: both ports on x4
    tick();
    idle_inputs();
    rs1_addr = 5'd4;
    #1;
    expect_v(8'd5, S_RS1, 64'h1234_5678_9ABC_DEF0);
    expect_v(8'd5, S_RS2, 64'h1234_5678_9ABC_DEF0);
    expect_v(8'd5, S_CC, 64'd2);
    fire();

    // 6: write to x0 is ignored
    wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 64'h1; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    expect_v(8'd6, S_RS1, 64'd0);
    expect_v(8'd6, S_RS2, 64'd0);
    fire();
    tick();
    idle_inputs();
    #1;
    expect_v(8'd7, S_RS2, 64'd0);
    expect_v(8'd7, S_CC, 64'd2);
    fire();

    // 8: write suppressed by exception; no bypass either
    wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 64'h55; rs1_addr = 5'd7;
    exc_in = 1'b1; exc_pc_in = 64'h8000_0010; exc_cause_in = 4'd2;
    #1;
    expect_v(8'd8, S_RS1, 64'd0);
    fire();
    tick();
    idle_inputs();
    #1;
    expect_v(8'd9, S_RS1, 64'd0);
    expect_v(8'd9, S_CC, 64'd2);
    expect_v(8'd9, S_TV, 64'd1);
    expect_v(8'd9, S_TPC, 64'h8000_0010);
    expect_v(8'd9, S_TC, 64'd2);
    expect_v(8'd9, S_OVR, 64'd0);
    fire();

    // 10: overrun keeps the first capture
    exc_in = 1'b1; exc_pc_in = 64'h20; exc_cause_in = 4'd5;
    tick();
    idle_inputs();
    #1;
    expect_v(8'd10, S_TV, 64'd1);
    expect_v(8'd10, S_TC, 64'd2);
    expect_v(8'd10, S_TPC, 64'h8000_0010);
    expect_v(8'd10, S_OVR, 64'd1);
    fire();

    // 11: ack drains the latch, clears overrun, data holds
    trap_ack = 1'b1;
    tick();
    idle_inputs();
    #1;
    expect_v(8'd11, S_TV, 64'd0);
    expect_v(8'd11, S_OVR, 64'd0);
    expect_v(8'd11, S_TPC, 64'h8000_0010);
    expect_v(8'd11, S_TC, 64'd2);
    fire();

    // 12: ack while empty is ignored
    trap_ack = 1'b1;
    tick();
    idle_inputs();
    #1;
    expect_v(8'd12, S_TV, 64'd0);
    fire();

    // 13: capture cause 2, then overrun it
    exc_in = 1'b1; exc_pc_in = 64'h100; exc_cause_in = 4'd2;
    tick();
    exc_pc_in = 64'h200; exc_cause_in = 4'd9;
    tick();
    idle_inputs();
    #1;
    expect_v(8'd13, S_TV, 64'd1);
    expect_v(8'd13, S_TC, 64'd2);
    expect_v(8'd13, S_TPC, 64'h100);
    expect_v(8'd13, S_OVR, 64'd1);
    fire();

    // 14: ack with simultaneous exception: lossless refill, overrun cleared
    trap_ack = 1'b1; exc_in = 1'b1; exc_pc_in = 64'h40; exc_cause_in = 4'd11;
    tick();
    idle_inputs();
    #1;
    expect_v(8'd14, S_TV, 64'd1);
    expect_v(8'd14, S_TC, 64'd11);
    expect_v(8'd14, S_TPC, 64'h40);
    expect_v(8'd14, S_OVR, 64'd0);
    fire();

    // 15: set overrun again, then async reset between edges
    exc_in = 1'b1; exc_pc_in = 64'h60; exc_cause_in = 4'd3;
    tick();
    idle_inputs();
    rs1_addr = 5'd3;
    #1;
    expect_v(8'd15, S_OVR, 64'd1);
    expect_v(8'd15, S_RS1, 64'hDEAD_BEEF);
    fire();
    #2;
    resetn = 1'b0;
    #1;
    expect_v(8'd16, S_TV, 64'd0);
    expect_v(8'd16, S_OVR, 64'd0);
    expect_v(8'd16, S_CC, 64'd0);
    expect_v(8'd16, S_TPC, 64'd0);
    expect_v(8'd16, S_TC, 64'd0);
    expect_v(8'd16, S_RS1, 64'd0);
    fire();
    tick();
    resetn = 1'b1;
    tick();
    #1;
    expect_v(8'd17, S_RS1, 64'd0);
    expect_v(8'd17, S_CC, 64'd0);
    fire();

    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
